// File: rtl/cdcc_pkg.sv
// Shared constants and types for the cached dilated causal convolution datapath.
package cdcc_pkg;

    localparam int W_DEFAULT = 16;
    localparam int N_TAPS    = 4;

    typedef logic signed [W_DEFAULT-1:0] sample_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/window_serializer.sv
// Parallel-in/serial-out for one N-element vector, element 0 first; 1-cycle load latency.
// Stalls on !out_ready_i; in_ready_o only while idle or handing off the last element.
module window_serializer
    import cdcc_pkg::*;
#(
    parameter int W = W_DEFAULT,
    parameter int N = N_TAPS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic signed [W-1:0]    in_data_i [0:N-1],
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic signed [W-1:0]    out_data_o,
    output logic [$clog2(N)-1:0]   out_idx_o,
    output logic                   out_last_o
);

    localparam int            IW       = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_t                state_q, state_d;
    logic signed [W-1:0]   hold_q [0:N-1];
    logic signed [W-1:0]   hold_d [0:N-1];
    logic [IW-1:0]         idx_q, idx_d;

    logic out_fire;
    logic load;

    assign out_valid_o = (state_q == SHIFT);
    assign out_last_o  = out_valid_o && (idx_q == LAST_IDX);
    assign out_data_o  = out_valid_o ? hold_q[0] : '0;
    assign out_idx_o   = idx_q;

    assign out_fire   = out_valid_o && out_ready_i;
    // A new vector may enter on the same edge the last element leaves, so there is no bubble.
    assign in_ready_o = !out_valid_o || (out_fire && out_last_o);
    assign load       = in_valid_i && in_ready_o;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        if (load) begin
            hold_d  = in_data_i;
            idx_d   = '0;
            state_d = SHIFT;
        end else if (out_fire) begin
            if (out_last_o) begin
                for (int k = 0; k < N; k++) begin
                    hold_d[k] = '0;
                end
                idx_d   = '0;
                state_d = IDLE;
            end else begin
                for (int k = 0; k < N - 1; k++) begin
                    hold_d[k] = hold_q[k+1];
                end
                hold_d[N-1] = '0;
                idx_d       = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            for (int k = 0; k < N; k++) begin
                hold_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
        end
    end

endmodule
